uart_rx: RTL

Oversampling UART receiver for 8N1 serial frames. It consumes the single-cycle `baud_tick` strobe from `baud_gen` (16 ticks per bit period) and samples the asynchronous `rx` line at each bit centre. It delivers each received byte to the pattern-matching logic as a one-cycle `rx_valid` pulse with `rx_data`, or flags a malformed frame on `frame_err`.

---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the baud source / line and the UART receiver.
// The receiver takes the slave view; whatever drives the line and the tick
// strobe (and consumes the received bytes) takes the master view.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport slave (
        input  baud_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport master (
        output baud_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver. The asynchronous rx line is synchronised,
// each bit is sampled at its centre using OVERSAMPLE baud ticks per bit, and
// every completed frame produces either a one-cycle rx_valid pulse with the
// byte on rx_data, or a one-cycle frame_err pulse when the stop bit is low.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      sys_clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q,     state_d;
    logic                 sync1_q,     sync1_d;
    logic                 rx_s_q,      rx_s_d;
    logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q,      busy_d;

    // Next-state logic: synchroniser, frame FSM, counters and output pulses.
    always_comb begin
        state_d     = state_q;
        sync1_d     = bus.rx;
        rx_s_d      = sync1_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A falling edge starts a frame without waiting for a tick,
                // so frames may follow each other with no idle gap.
                tick_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        // Start-bit centre: still low means a real start bit,
                        // high means it was only a glitch.
                        if (!rx_s_q) begin
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // Right shift so LSB-first bits end up in order.
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            // Keep the previous byte; wait out the low line.
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            S_BREAK: begin
                // A line held low must not decode as a stream of frames.
                tick_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                tick_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops any partial frame at once.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule
